// File: rtl/cpu_strap_sampler.sv
// rtl/cpu_strap_sampler.sv - CPU strap synchronizer, debouncer and snapshot latch
// Freezes a glitch-free strap snapshot after aux power settles; also debounces live socket occupancy.
module cpu_strap_sampler #(
   parameter int SETTLE_CYCLES  = 1000,
   parameter int STABLE_CYCLES  = 16,
   parameter int TIMEOUT_CYCLES = 4096,
   parameter int OCC_DEB_CYCLES = 16
) (
   input  logic       iClk,
   input  logic       iRst,
   input  logic       iAuxPwrDone,
   input  logic       iRearm,
   input  logic [1:0] invSktOccRaw,
   input  logic [1:0] ivProcID1Raw,
   input  logic [1:0] ivProcID2Raw,
   input  logic [2:0] ivPkgID1Raw,
   input  logic [2:0] ivPkgID2Raw,
   input  logic [1:0] ivIntrRaw,
   output logic [1:0] onvSktOcc,
   output logic [1:0] ovProcID1,
   output logic [1:0] ovProcID2,
   output logic [2:0] ovPkgID1,
   output logic [2:0] ovPkgID2,
   output logic [1:0] ovIntr,
   output logic [1:0] onvSktOccLive,
   output logic       oSampleDone,
   output logic       oStrapUnstable
);

   localparam int SettleW  = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
   localparam int StableW  = (STABLE_CYCLES  > 1) ? $clog2(STABLE_CYCLES)  : 1;
   localparam int TimeoutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam int OccW     = (OCC_DEB_CYCLES > 1) ? $clog2(OCC_DEB_CYCLES) : 1;

   localparam logic [SettleW-1:0]  SettleLast  = SettleW'(SETTLE_CYCLES - 1);
   localparam logic [StableW-1:0]  StableLast  = StableW'(STABLE_CYCLES - 1);
   localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);
   localparam logic [OccW-1:0]     OccLast     = OccW'(OCC_DEB_CYCLES - 1);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] SETTLE = 2'd1;
   localparam logic [1:0] FILTER = 2'd2;
   localparam logic [1:0] LOCKED = 2'd3;

   localparam int BW = 14;
   // Socket-occupied is active-low, so "nothing present" is all ones in the top two bits
   localparam logic [BW-1:0] RstBundle = {2'b11, 12'd0};

   logic [BW-1:0]       rawBundle;
   logic [BW-1:0]       syncMeta;
   logic [BW-1:0]       syncBundle;
   logic [BW-1:0]       prevBundle;
   logic [BW-1:0]       snapBundle;
   logic [1:0]          state;
   logic [SettleW-1:0]  settleCnt;
   logic [StableW-1:0]  stableCnt;
   logic [TimeoutW-1:0] timeoutCnt;
   logic                bundleSame;
   logic                stableHit;
   logic                timeoutHit;
   logic [1:0]          liveOcc;

   assign rawBundle = {invSktOccRaw, ivProcID2Raw, ivProcID1Raw,
                       ivPkgID2Raw, ivPkgID1Raw, ivIntrRaw};

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         syncMeta   <= RstBundle;
         syncBundle <= RstBundle;
      end else begin
         syncMeta   <= rawBundle;
         syncBundle <= syncMeta;
      end
   end

   assign bundleSame = (syncBundle == prevBundle);
   assign stableHit  = bundleSame && (stableCnt == StableLast);
   assign timeoutHit = (timeoutCnt == TimeoutLast);

   always_ff @(posedge iClk or posedge iRst) begin
      if (iRst) begin
         state          <= IDLE;
         settleCnt      <= '0;
         stableCnt      <= '0;
         timeoutCnt     <= '0;
         prevBundle     <= '0;
         snapBundle     <= RstBundle;
         oSampleDone    <= 1'b0;
         oStrapUnstable <= 1'b0;
      end else if (state == IDLE) begin
         oSampleDone <= 1'b0;
         if (iAuxPwrDone) begin
            state     <= SETTLE;
            settleCnt <= '0;
         end
      end else if (!iAuxPwrDone) begin
         // Power loss beats everything, including a same-cycle rearm
         state       <= IDLE;
         oSampleDone <= 1'b0;
      end else begin
         case (state)
            SETTLE: begin
               if (settleCnt == SettleLast) begin
                  state      <= FILTER;
                  stableCnt  <= '0;
                  timeoutCnt <= '0;
                  prevBundle <= '0;
               end else begin
                  settleCnt <= settleCnt + 1'b1;
               end
            end
            FILTER: begin
               prevBundle <= syncBundle;
               if (timeoutCnt != TimeoutLast)
                  timeoutCnt <= timeoutCnt + 1'b1;
               if (!bundleSame)
                  stableCnt <= '0;
               else if (stableCnt != StableLast)
                  stableCnt <= stableCnt + 1'b1;
               if (stableHit) begin
                  snapBundle <= syncBundle;
                  state      <= LOCKED;
               end else if (timeoutHit) begin
                  snapBundle     <= syncBundle;
                  oStrapUnstable <= 1'b1;
                  state          <= LOCKED;
               end
            end
            LOCKED: begin
               if (iRearm) begin
                  state       <= FILTER;
                  oSampleDone <= 1'b0;
                  stableCnt   <= '0;
                  timeoutCnt  <= '0;
                  prevBundle  <= '0;
               end else begin
                  oSampleDone <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Live occupancy debounce runs regardless of FSM state or aux power
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : gOccDeb
         logic [OccW-1:0] occCnt;
         always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
               occCnt      <= '0;
               liveOcc[gi] <= 1'b1;
            end else if (syncBundle[12+gi] != liveOcc[gi]) begin
               if (occCnt == OccLast) begin
                  liveOcc[gi] <= syncBundle[12+gi];
                  occCnt      <= '0;
               end else begin
                  occCnt <= occCnt + 1'b1;
               end
            end else begin
               occCnt <= '0;
            end
         end
      end
   endgenerate

   assign onvSktOcc     = snapBundle[13:12];
   assign ovProcID2     = snapBundle[11:10];
   assign ovProcID1     = snapBundle[9:8];
   assign ovPkgID2      = snapBundle[7:5];
   assign ovPkgID1      = snapBundle[4:2];
   assign ovIntr        = snapBundle[1:0];
   assign onvSktOccLive = liveOcc;

endmodule

// File: tb/tb_cpu_strap_sampler.sv
// tb/tb_cpu_strap_sampler.sv - scoreboard bench for cpu_strap_sampler
module tb_cpu_strap_sampler;

   logic       iClk = 1'b0;
   logic       iRst;
   logic       iAuxPwrDone;
   logic       iRearm;
   logic [1:0] invSktOccRaw;
   logic [1:0] ivProcID1Raw;
   logic [1:0] ivProcID2Raw;
   logic [2:0] ivPkgID1Raw;
   logic [2:0] ivPkgID2Raw;
   logic [1:0] ivIntrRaw;
   logic [1:0] onvSktOcc;
   logic [1:0] ovProcID1;
   logic [1:0] ovProcID2;
   logic [2:0] ovPkgID1;
   logic [2:0] ovPkgID2;
   logic [1:0] ovIntr;
   logic [1:0] onvSktOccLive;
   logic       oSampleDone;
   logic       oStrapUnstable;

   cpu_strap_sampler #(
      .SETTLE_CYCLES (8),
      .STABLE_CYCLES (4),
      .TIMEOUT_CYCLES(32),
      .OCC_DEB_CYCLES(4)
   ) dut (
      .iClk          (iClk),
      .iRst          (iRst),
      .iAuxPwrDone   (iAuxPwrDone),
      .iRearm        (iRearm),
      .invSktOccRaw  (invSktOccRaw),
      .ivProcID1Raw  (ivProcID1Raw),
      .ivProcID2Raw  (ivProcID2Raw),
      .ivPkgID1Raw   (ivPkgID1Raw),
      .ivPkgID2Raw   (ivPkgID2Raw),
      .ivIntrRaw     (ivIntrRaw),
      .onvSktOcc     (onvSktOcc),
      .ovProcID1     (ovProcID1),
      .ovProcID2     (ovProcID2),
      .ovPkgID1      (ovPkgID1),
      .ovPkgID2      (ovPkgID2),
      .ovIntr        (ovIntr),
      .onvSktOccLive (onvSktOccLive),
      .oSampleDone   (oSampleDone),
      .oStrapUnstable(oStrapUnstable)
   );

   always #5 iClk = ~iClk;

   int cyc = 0;
   always @(posedge iClk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      bit          rise;
      logic [13:0] bnd;
      logic        uns;
   } expT;

   expT  expQ[$];
   int   checks = 0;
   int   errors = 0;
   bit   stimDone = 1'b0;
   logic [13:0] actB;
   assign actB = {onvSktOcc, ovProcID2, ovProcID1, ovPkgID2, ovPkgID1, ovIntr};

   function automatic logic [13:0] mk(input logic [1:0] occ, input logic [1:0] p2,
                                      input logic [1:0] p1, input logic [2:0] k2,
                                      input logic [2:0] k1, input logic [1:0] it);
      return {occ, p2, p1, k2, k1, it};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge iClk);
      #1;
   endtask

   task automatic pushExp(input int c, input bit r, input logic [13:0] b, input logic u);
      expT e;
      e.cyc = c; e.rise = r; e.bnd = b; e.uns = u;
      expQ.push_back(e);
   endtask

   function automatic logic togBit(input int k);
      return 1'b1 ^ (((k + 1) / 3) % 2 == 1);
   endfunction

   initial begin
      int n;
      int m;
      int bad;
      iRst = 1'b1; iAuxPwrDone = 1'b0; iRearm = 1'b0;
      invSktOccRaw = 2'b10; ivProcID1Raw = 2'b00; ivProcID2Raw = 2'b10;
      ivPkgID1Raw = 3'b001; ivPkgID2Raw = 3'b101; ivIntrRaw = 2'b00;
      fork
         begin
            #3;
            chk("rst_bundle", 32'(actB), 32'(mk(2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00)));
            chk("rst_live", 32'(onvSktOccLive), 32'h3);
            chk("rst_done", 32'(oSampleDone), 32'h0);
            chk("rst_unstable", 32'(oStrapUnstable), 32'h0);
            tick(3);
            iRst = 1'b0;
            tick(8);
            chk("live_after_rst", 32'(onvSktOccLive), 32'h2);

            // stable straps: done exactly 15 cycles after the aux rise
            n = cyc;
            iAuxPwrDone = 1'b1;
            pushExp(n + 15, 1'b1, mk(2'b10, 2'b10, 2'b00, 3'b101, 3'b001, 2'b00), 1'b0);
            tick(20);

            // locked outputs ignore pins, then rearm picks up the new ID
            ivProcID1Raw = 2'b01;
            tick(6);
            chk("locked_frozen", 32'(actB), 32'(mk(2'b10, 2'b10, 2'b00, 3'b101, 3'b001, 2'b00)));
            m = cyc;
            iRearm = 1'b1;
            pushExp(m + 1, 1'b0, '0, 1'b0);
            pushExp(m + 7, 1'b1, mk(2'b10, 2'b10, 2'b01, 3'b101, 3'b001, 2'b00), 1'b0);
            tick(1);
            iRearm = 1'b0;
            tick(12);

            // aux drop from LOCKED, ignored rearm in IDLE, aborted settle, full settle again
            m = cyc;
            iAuxPwrDone = 1'b0;
            pushExp(m + 1, 1'b0, '0, 1'b0);
            tick(3);
            iRearm = 1'b1;
            tick(1);
            iRearm = 1'b0;
            tick(2);
            iAuxPwrDone = 1'b1;
            tick(4);
            iAuxPwrDone = 1'b0;
            tick(3);
            chk("abort_settle_done", 32'(oSampleDone), 32'h0);
            n = cyc;
            iAuxPwrDone = 1'b1;
            pushExp(n + 15, 1'b1, mk(2'b10, 2'b10, 2'b01, 3'b101, 3'b001, 2'b00), 1'b0);
            tick(20);

            // toggling pkgID1[0] forces the timeout path
            m = cyc;
            iAuxPwrDone = 1'b0;
            pushExp(m + 1, 1'b0, '0, 1'b0);
            tick(3);
            n = cyc;
            ivPkgID1Raw = {2'b00, togBit(0)};
            iAuxPwrDone = 1'b1;
            pushExp(n + 42, 1'b1, mk(2'b10, 2'b10, 2'b01, 3'b101, 3'b000, 2'b00), 1'b1);
            for (int k = 1; k <= 45; k++) begin
               tick(1);
               ivPkgID1Raw = {2'b00, togBit(k)};
            end
            ivPkgID1Raw = 3'b001;
            tick(5);

            // live occupancy in IDLE: glitch rejected, sustained change accepted
            m = cyc;
            iAuxPwrDone = 1'b0;
            pushExp(m + 1, 1'b0, '0, 1'b0);
            tick(2);
            invSktOccRaw = 2'b00;
            tick(8);
            chk("live_both_occ", 32'(onvSktOccLive), 32'h0);
            invSktOccRaw = 2'b10;
            tick(3);
            invSktOccRaw = 2'b00;
            bad = 0;
            for (int k = 0; k < 8; k++) begin
               tick(1);
               if (onvSktOccLive != 2'b00) bad++;
            end
            chk("live_glitch_rejected", 32'(bad), 32'h0);
            invSktOccRaw = 2'b10;
            tick(5);
            chk("live_before_deb", 32'(onvSktOccLive), 32'h0);
            tick(1);
            chk("live_after_deb", 32'(onvSktOccLive), 32'h2);
            chk("idle_retains", 32'(actB), 32'(mk(2'b10, 2'b10, 2'b01, 3'b101, 3'b000, 2'b00)));
            chk("idle_unstable_sticky", 32'(oStrapUnstable), 32'h1);

            // async reset while LOCKED
            n = cyc;
            iAuxPwrDone = 1'b1;
            pushExp(n + 15, 1'b1, mk(2'b10, 2'b10, 2'b01, 3'b101, 3'b001, 2'b00), 1'b1);
            tick(20);
            pushExp(-1, 1'b0, '0, 1'b0);
            #2;
            iRst = 1'b1;
            #1;
            chk("async_rst_bundle", 32'(actB), 32'(mk(2'b11, 2'b00, 2'b00, 3'b000, 3'b000, 2'b00)));
            chk("async_rst_live", 32'(onvSktOccLive), 32'h3);
            chk("async_rst_done", 32'(oSampleDone), 32'h0);
            chk("async_rst_unstable", 32'(oStrapUnstable), 32'h0);
            tick(3);
            iRst = 1'b0;
            tick(3);
            chk("queue_drained", 32'(expQ.size()), 32'h0);
            stimDone = 1'b1;
         end
         begin
            logic donePrev;
            expT  e;
            donePrev = 1'b0;
            while (!stimDone) begin
               @(negedge iClk);
               if (oSampleDone !== donePrev) begin
                  if (expQ.size() == 0) begin
                     chk("unexpected_done_edge", 32'(oSampleDone), 32'(donePrev));
                  end else begin
                     e = expQ.pop_front();
                     chk("done_edge_dir", 32'(oSampleDone), 32'(e.rise));
                     if (e.cyc >= 0) chk("done_edge_cycle", 32'(cyc), 32'(e.cyc));
                     if (e.rise) begin
                        chk("snap_bundle", 32'(actB), 32'(e.bnd));
                        chk("snap_unstable", 32'(oStrapUnstable), 32'(e.uns));
                     end
                  end
               end
               donePrev = oSampleDone;
            end
         end
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
